// File: rtl/bcd_pkg.sv
// Shared constants and types for packed-BCD arithmetic.
//   BCD_MAX     : largest legal decimal digit value
//   BCD_ADJ     : correction added to a binary digit sum that overflows 9
//   bcd_digit_t : one 4-bit BCD digit
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder, purely combinational.
//   a, b : BCD digits (values above 9 are flagged on bad, still summed)
//   ci   : carry-in, weight 1
//   s    : corrected BCD sum digit
//   co   : decimal carry-out
//   bad  : a or b is not a legal BCD digit
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       ci,
  output bcd_digit_t s,
  output logic       co,
  output logic       bad
);
  logic [4:0] u;
  logic [4:0] u_adj;

  always_comb begin
    // 5 bits covers the worst illegal case 15 + 15 + 1 = 31.
    u     = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    u_adj = u + {1'b0, BCD_ADJ};
    if (u > {1'b0, BCD_MAX}) begin
      s  = u_adj[3:0];
      co = 1'b1;
    end else begin
      s  = u[3:0];
      co = 1'b0;
    end
    bad = (a > BCD_MAX) || (b > BCD_MAX);
  end
endmodule

// File: rtl/two_decimal_adder.sv
// Two-digit packed-BCD adder with registered outputs (1-cycle latency,
// one operand set accepted every cycle).
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   A, B : packed-BCD operands, [7:4] tens, [3:0] units
//   Cin  : decimal carry-in
//   S    : registered packed-BCD sum, modulo 100
//   Cout : registered decimal carry-out (sum >= 100)
//   err  : registered flag, some input nibble exceeded 9
module two_decimal_adder
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout,
  output logic       err
);
  bcd_digit_t units_s, tens_s;
  logic       c1, tens_co;
  logic       units_bad, tens_bad;

  logic [7:0] s_d, s_q;
  logic       cout_d, cout_q;
  logic       err_d, err_q;

  bcd_digit_adder u_units (
    .a   (A[3:0]),
    .b   (B[3:0]),
    .ci  (Cin),
    .s   (units_s),
    .co  (c1),
    .bad (units_bad)
  );

  bcd_digit_adder u_tens (
    .a   (A[7:4]),
    .b   (B[7:4]),
    .ci  (c1),
    .s   (tens_s),
    .co  (tens_co),
    .bad (tens_bad)
  );

  always_comb begin
    s_d    = {tens_s, units_s};
    cout_d = tens_co;
    err_d  = units_bad | tens_bad;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 8'h00;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      err_q  <= err_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign err  = err_q;
endmodule

// File: tb/tb_two_decimal_adder.sv
module tb_two_decimal_adder;
  logic       clk;
  logic       rst;
  logic [7:0] A, B;
  logic       Cin;
  logic [7:0] S;
  logic       Cout, err;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  two_decimal_adder dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Drive one operand set just after the falling edge and queue its result.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] es, input logic ec, input logic ee);
    exp_t x;
    @(negedge clk);
    A = a; B = b; Cin = cin;
    x.a = a; x.b = b; x.cin = cin; x.s = es; x.c = ec; x.e = ee;
    exp_q.push_back(x);
  endtask

  // Results are checked 1 ns after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (!rst && exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk($sformatf("S a=%h b=%h ci=%0d", x.a, x.b, x.cin), S, x.s);
      chk($sformatf("Cout a=%h b=%h ci=%0d", x.a, x.b, x.cin), {7'd0, Cout}, {7'd0, x.c});
      chk($sformatf("err a=%h b=%h ci=%0d", x.a, x.b, x.cin), {7'd0, err}, {7'd0, x.e});
    end
  end

  task automatic drain();
    int budget;
    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    chk("drain", 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    int sum;
    rst = 1'b1; A = 8'h00; B = 8'h00; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst S", S, 8'h00);
    chk("rst Cout", {7'd0, Cout}, 8'd0);
    chk("rst err", {7'd0, err}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases back-to-back, one per cycle.
    drive(8'h05, 8'h01, 1'b0, 8'h06, 1'b0, 1'b0);
    drive(8'h31, 8'h35, 1'b0, 8'h66, 1'b0, 1'b0);
    drive(8'h57, 8'h90, 1'b0, 8'h47, 1'b1, 1'b0);
    drive(8'h09, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    drive(8'h99, 8'h99, 1'b1, 8'h99, 1'b1, 1'b0);
    drain();

    // Mid-stream async reset: outputs clear without a clock edge.
    drive(8'h12, 8'h77, 1'b1, 8'h90, 1'b0, 1'b0);
    drain();
    @(posedge clk);
    #3;
    chk("pre-rst S", S, 8'h90);
    A = 8'h55; B = 8'h44; Cin = 1'b1;
    rst = 1'b1;
    #1;
    chk("async rst S", S, 8'h00);
    chk("async rst Cout", {7'd0, Cout}, 8'd0);
    chk("async rst err", {7'd0, err}, 8'd0);
    @(posedge clk);
    #1;
    chk("hold rst S", S, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(8'h05, 8'h01, 1'b0, 8'h06, 1'b0, 1'b0);
    drain();

    // Invalid nibbles: flagged, result follows the digit correction.
    drive(8'h0A, 8'h00, 1'b0, 8'h10, 1'b0, 1'b1);
    drive(8'hA0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    drive(8'h00, 8'h0F, 1'b0, 8'h15, 1'b0, 1'b1);
    drive(8'h42, 8'h13, 1'b0, 8'h55, 1'b0, 1'b0);
    drain();

    // Exhaustive valid sweep against a decimal reference.
    for (int a = 0; a < 100; a++)
      for (int b = 0; b < 100; b++)
        for (int c = 0; c < 2; c++) begin
          sum = a + b + c;
          drive(to_bcd(a), to_bcd(b), 1'(c), to_bcd(sum % 100), sum >= 100, 1'b0);
        end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
